// File: rtl/slatchp_vec.sv
`default_nettype none
// ============================================================================
// Module      : slatchp_vec
// Description : Byte-lane enabled, edge-loaded vector latch emulation with
//               synchronous preset and optional shadow/commit double buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module slatchp_vec #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}},
    parameter int               DBUF    = 0
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               cp,
    input  logic [WIDTH-1:0]   d,
    input  logic [WIDTH/8-1:0] en,
    input  logic               setl,
    input  logic               commit,
    output logic [WIDTH-1:0]   q,
    output logic [WIDTH-1:0]   qn,
    output logic               upd,
    output logic               pend
);

    localparam int c_LANES = WIDTH / 8;

    logic             r_cp_d;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_shadow;
    logic             r_pend;
    logic             r_upd;

    logic             w_edge;
    logic [WIDTH-1:0] w_merge_q;
    logic [WIDTH-1:0] w_merge_sh;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_sh_nxt;
    logic             w_pend_nxt;

    // r_cp_d resets high so a cp held high across reset release is not an edge
    assign w_edge = cp & ~r_cp_d;

    always_comb begin
        w_merge_q  = r_q;
        w_merge_sh = r_shadow;
        for (int i = 0; i < c_LANES; i++) begin
            if (en[i]) begin
                w_merge_q[8*i +: 8]  = d[8*i +: 8];
                w_merge_sh[8*i +: 8] = d[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_q_nxt    = r_q;
        w_sh_nxt   = r_shadow;
        w_pend_nxt = r_pend;
        if (!setl) begin
            w_q_nxt    = SET_VAL;
            w_sh_nxt   = SET_VAL;
            w_pend_nxt = 1'b0;
        end else if (DBUF == 0) begin
            if (w_edge) begin
                w_q_nxt = w_merge_q;
            end
        end else if (w_edge && commit) begin
            // write-through: the freshly merged shadow goes straight to q
            w_q_nxt    = w_merge_sh;
            w_sh_nxt   = w_merge_sh;
            w_pend_nxt = 1'b0;
        end else if (w_edge) begin
            w_sh_nxt = w_merge_sh;
            if (|en) begin
                w_pend_nxt = 1'b1;
            end
        end else if (commit) begin
            w_q_nxt    = r_shadow;
            w_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_cp_d   <= 1'b1;
            r_q      <= '0;
            r_shadow <= '0;
            r_pend   <= 1'b0;
            r_upd    <= 1'b0;
        end else begin
            r_cp_d   <= cp;
            r_q      <= w_q_nxt;
            r_shadow <= w_sh_nxt;
            r_pend   <= w_pend_nxt;
            r_upd    <= (w_q_nxt != r_q);
        end
    end

    generate
        if (DBUF != 0) begin : g_pend_buf
            assign pend = r_pend;
        end else begin : g_pend_tied
            assign pend = 1'b0;
        end
    endgenerate

    assign q   = r_q;
    assign qn  = ~r_q;
    assign upd = r_upd;

endmodule
`default_nettype wire

// File: doc/slatchp_vec.md
SLATCHP_VEC -- requirements
Module: slatchp_vec

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- WIDTH, 16, data width in bits; SHALL be a multiple of 8, range 8..64.
- SET_VAL, {WIDTH{1'b1}}, value forced by preset.
- DBUF, 0, 0 = direct load; 1 = double-buffered (shadow plus commit).

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- sys_clk, in, 1, the only clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-high.
- cp, in, 1, logic-clock level, synchronous to sys_clk; a load event is a 0->1 transition.
- d, in, WIDTH, load data.
- en, in, WIDTH/8, byte-lane load enables; bit i covers d[8i+7:8i].
- setl, in, 1, synchronous preset, active-low.
- commit, in, 1, shadow-to-output transfer strobe; ignored when DBUF=0.
- q, out, WIDTH, registered output.
- qn, out, WIDTH, ~q (combinational).
- upd, out, 1, one-cycle pulse marking that q changed.
- pend, out, 1, shadow holds uncommitted data; tied 0 when DBUF=0.

REQ-003 The one clock is sys_clk; reset is synchronous and active-high.

Function
REQ-004 The block SHALL register cp into cp_d every cycle; edge = cp & ~cp_d (combinational, same cycle).
REQ-005 The per-cycle priority SHALL be: reset > setl=0 > edge/commit > hold.
REQ-006 When setl=0, the block SHALL set q <= SET_VAL, shadow <= SET_VAL and pend <= 0, ignoring edge, en, d and commit that cycle.
REQ-007 DBUF=0: on edge, for each lane i with en[i]=1, q lane i SHALL be loaded from d lane i; all other lanes SHALL hold. Latency: d and en are sampled in the edge cycle and the new q is visible the next cycle.
REQ-008 DBUF=0: edge with en = 0 SHALL leave q unchanged.
REQ-009 DBUF=1: on edge, the enabled lanes of shadow SHALL load from d and q SHALL hold; pend <= 1 if any en bit is set, otherwise pend holds.
REQ-010 DBUF=1: commit without edge SHALL set q <= shadow and pend <= 0; commit with pend=0 is legal and leaves q unchanged.
REQ-011 DBUF=1: edge and commit in the same cycle SHALL write through:
- q <= shadow with the enabled lanes replaced by d;
- shadow updated identically;
- pend <= 0.
REQ-012 upd SHALL be high for exactly the cycle in which a new q value first appears, and only if the new value differs from the previous one; this includes changes caused by setl.
REQ-013 A held cp (no 0->1 transition) SHALL never generate more than one load.
REQ-014 qn SHALL equal ~q at all times.

Reset
REQ-015 While reset=1 the block SHALL set q = 0, shadow = 0, pend = 0, upd = 0, cp_d = 1.
REQ-016 With cp_d resetting to 1, a cp held high through reset release SHALL NOT produce a load; a reset in the same cycle as an edge, setl or commit SHALL win.
REQ-017 qn SHALL read all ones during and immediately after reset.

Verification
REQ-018 Reset release with cp=1 held -> no load, q=0x0000, upd=0; then cp 1->0->1 with d=0xA55A, en=2'b11 -> q=0xA55A one cycle after the edge, upd pulses once.
REQ-019 DBUF=0, q=0xA55A; edge with d=0x1234, en=2'b01 -> q=0xA534; edge with en=2'b00 -> q unchanged, upd=0.
REQ-020 setl=0 in the same cycle as an edge with d=0x0000, en=2'b11 -> q=0xFFFF (SET_VAL default), upd=1, pend=0.
REQ-021 DBUF=1: edge with d=0x00FF, en=2'b11 -> q unchanged, pend=1; commit -> q=0x00FF, pend=0, upd=1; a second commit -> upd=0.
REQ-022 DBUF=1, shadow=0x00FF: edge and commit in the same cycle with d=0xAB00, en=2'b10 -> q=0xABFF, shadow=0xABFF, pend=0.
REQ-023 WIDTH=32: reset asserted mid-sequence, one cycle after an edge -> all state at reset values the next cycle; qn=0xFFFFFFFF.
